// File: rtl/pid_scheduler.sv
// pid_scheduler: sample-tick driven round-robin scheduler for a shared PID datapath.
// Optional watchdog abort in WAIT is enabled by defining PID_SCHED_WATCHDOG_EN.
module pid_scheduler #(
   parameter int PRESCALE = 1000,
   parameter int TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  ch_en,
   input  logic [31:0] target_vel,
   input  logic [31:0] current_vel,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_ch,
   input  logic [3:0]  cfg_kp,
   input  logic [3:0]  cfg_ki,
   input  logic [3:0]  cfg_kd,
   output logic        pid_start,
   output logic [1:0]  pid_ch,
   output logic [7:0]  pid_target,
   output logic [7:0]  pid_current,
   output logic [3:0]  pid_kp,
   output logic [3:0]  pid_ki,
   output logic [3:0]  pid_kd,
   input  logic        pid_done,
   input  logic [7:0]  pid_result,
   output logic [31:0] vel_out,
   output logic [3:0]  vel_valid,
   output logic        busy,
   output logic        overrun,
   output logic [3:0]  timeout_err,
   input  logic        err_clr
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] STORE = 2'd3;

   logic [1:0]  state;
   logic [15:0] cnt;
   logic        tick;
   logic [3:0]  mask;
   logic [3:0]  src_mask;
   logic        go_issue;
   logic [1:0]  sel;
   logic        wd_abort;
   logic [3:0]  kp_r [4];
   logic [3:0]  ki_r [4];
   logic [3:0]  kd_r [4];

   assign tick = (cnt == 16'(PRESCALE - 1));
   assign busy = (state != IDLE);

`ifdef PID_SCHED_WATCHDOG_EN
   logic [15:0] wcnt;

   assign wd_abort = (state == WAIT) && !pid_done &&
                     (wcnt == 16'(TIMEOUT - 1));

   // WAIT-cycle counter and sticky per-channel timeout flags
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt        <= 16'd0;
         timeout_err <= 4'b0000;
      end else begin
         if (state == WAIT) wcnt <= wcnt + 16'd1;
         else               wcnt <= 16'd0;
         if (err_clr)       timeout_err <= 4'b0000;
         else if (wd_abort) timeout_err[pid_ch] <= 1'b1;
      end
   end
`else
   assign wd_abort    = 1'b0;
   assign timeout_err = 4'b0000;
`endif

   // Mask the next issue picks from, and whether an issue happens this edge
   always_comb begin
      src_mask = mask;
      go_issue = 1'b0;
      case (state)
         IDLE: begin
            src_mask = ch_en;
            go_issue = tick && (ch_en != 4'b0000);
         end
         WAIT: begin
            src_mask = mask & ~(4'b0001 << pid_ch);
            go_issue = wd_abort && (src_mask != 4'b0000);
         end
         STORE: go_issue = (mask != 4'b0000);
         default: ;
      endcase
   end

   // Lowest-index remaining channel
   always_comb begin
      if (src_mask[0])      sel = 2'd0;
      else if (src_mask[1]) sel = 2'd1;
      else if (src_mask[2]) sel = 2'd2;
      else                  sel = 2'd3;
   end

   // Gain register file; an operand latch on the same edge sees the old value
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            kp_r[i] <= 4'd0;
            ki_r[i] <= 4'd0;
            kd_r[i] <= 4'd0;
         end
      end else if (cfg_we) begin
         kp_r[cfg_ch] <= cfg_kp;
         ki_r[cfg_ch] <= cfg_ki;
         kd_r[cfg_ch] <= cfg_kd;
      end
   end

   // Prescaler, scan FSM, operand latch, result store and overrun flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 16'd0;
         mask        <= 4'b0000;
         pid_start   <= 1'b0;
         pid_ch      <= 2'd0;
         pid_target  <= 8'd0;
         pid_current <= 8'd0;
         pid_kp      <= 4'd0;
         pid_ki      <= 4'd0;
         pid_kd      <= 4'd0;
         vel_out     <= 32'd0;
         vel_valid   <= 4'b0000;
         overrun     <= 1'b0;
      end else begin
         pid_start <= 1'b0;
         vel_valid <= 4'b0000;
         cnt       <= tick ? 16'd0 : cnt + 16'd1;

         if (err_clr)           overrun <= 1'b0;
         else if (tick && busy) overrun <= 1'b1;

         case (state)
            IDLE: if (tick) mask <= ch_en;
            ISSUE: state <= WAIT;
            WAIT: begin
               if (pid_done) begin
                  vel_out[8*pid_ch +: 8] <= pid_result;
                  vel_valid[pid_ch]      <= 1'b1;
                  mask                   <= src_mask;
                  state                  <= STORE;
               end else if (wd_abort) begin
                  mask  <= src_mask;
                  state <= IDLE;
               end
            end
            STORE: state <= IDLE;
            default: state <= IDLE;
         endcase

         if (go_issue) begin
            pid_ch      <= sel;
            pid_target  <= target_vel[8*sel +: 8];
            pid_current <= current_vel[8*sel +: 8];
            pid_kp      <= kp_r[sel];
            pid_ki      <= ki_r[sel];
            pid_kd      <= kd_r[sel];
            pid_start   <= 1'b1;
            state       <= ISSUE;
         end
      end
   end

endmodule

// File: doc/pid_scheduler.md
PID_SCHEDULER -- requirements
Module: pid_scheduler

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000, meaning clk cycles per sample period (legal range 8..65535).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles before a watchdog abort.
REQ-003 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ch_en  in  4  per-channel enable mask.
REQ-006 SHALL have port target_vel  in  32  four 8-bit targets, channel n at bits [8n+7:8n].
REQ-007 SHALL have port current_vel  in  32  four 8-bit measured velocities, same packing.
REQ-008 SHALL have port cfg_we  in  1  gain write strobe.
REQ-009 SHALL have port cfg_ch  in  2  gain write channel index.
REQ-010 SHALL have port cfg_kp/cfg_ki/cfg_kd  in  4 each  gain write data.
REQ-011 SHALL have port pid_start  out  1  one-cycle request to the shared PID datapath.
REQ-012 SHALL have port pid_ch  out  2  channel being served.
REQ-013 SHALL have port pid_target/pid_current  out  8 each  operands to the datapath.
REQ-014 SHALL have port pid_kp/pid_ki/pid_kd  out  4 each  gains to the datapath.
REQ-015 SHALL have port pid_done  in  1  one-cycle completion from the datapath.
REQ-016 SHALL have port pid_result  in  8  datapath result, valid with pid_done.
REQ-017 SHALL have port vel_out  out  32  four 8-bit registered results, same packing as target_vel.
REQ-018 SHALL have port vel_valid  out  4  one-cycle update strobe per channel.
REQ-019 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.
REQ-020 SHALL have port overrun  out  1  sticky flag, set when a sample tick arrives while busy.
REQ-021 SHALL have port timeout_err  out  4  sticky per-channel watchdog flags.
REQ-022 SHALL have port err_clr  in  1  clears overrun and timeout_err.

Function
REQ-023 SHALL count 0..PRESCALE-1 continuously and assert an internal tick in the cycle the count equals PRESCALE-1.
REQ-024 SHALL implement the states IDLE, ISSUE, WAIT and STORE.
REQ-025 SHALL, on a tick in IDLE, snapshot ch_en into a scan mask and go to ISSUE if the mask is nonzero; if the mask is zero it SHALL stay in IDLE.
REQ-026 SHALL, in ISSUE, select the lowest-index remaining channel in the scan mask with no skip cycles, latch its operands and gains into the pid_* registers, pulse pid_start for exactly one cycle, and go to WAIT.
REQ-027 SHALL hold all pid_* operand outputs stable from pid_start until the cycle after pid_done.
REQ-028 SHALL, on pid_done in WAIT, write pid_result to the served channel's vel_out slice, pulse its vel_valid bit in the same cycle vel_out changes (STORE), and clear that channel's bit in the scan mask.
REQ-029 SHALL, after STORE, go to ISSUE if scan mask bits remain, else to IDLE.
REQ-030 SHALL ignore pid_done outside WAIT.
REQ-031 SHALL, when a tick occurs while busy, drop the tick, set overrun, and leave the scan undisturbed.
REQ-032 SHALL apply a cfg_we write to the gain registers on the next edge; an operand latch in the same cycle SHALL use the old gains.
REQ-033 SHALL ignore ch_en changes during a scan; they SHALL take effect at the next tick.
REQ-034 SHALL give err_clr precedence over a simultaneous set of overrun or timeout_err, so the flag reads 0.
REQ-035 SHALL place the first pid_start exactly 1 cycle after the tick cycle.

Reset
REQ-036 SHALL, while rst is high, force the state to IDLE, the prescale count to 0, the scan mask to 0, all gains to 0, and vel_out, vel_valid, pid_* outputs, busy, overrun and timeout_err to 0.
REQ-037 SHALL, when rst is asserted mid-scan, abort the scan with pid_start low on the next edge, and SHALL discard any later pid_done.

Configuration
REQ-038 SHALL, with PID_SCHED_WATCHDOG_EN defined, abort the served channel when WAIT lasts TIMEOUT cycles without pid_done: set its timeout_err bit, leave vel_out unchanged, issue no vel_valid, clear its mask bit, and continue as in REQ-029.
REQ-039 SHALL, without PID_SCHED_WATCHDOG_EN, wait indefinitely in WAIT, tie timeout_err to 0, and ignore TIMEOUT.

Verification
REQ-040 SHALL cover: PRESCALE=16, ch_en=4'b1111, datapath responds with done 3 cycles after start, result=0x10+ch -> four starts in channel order 0..3, vel_out=0x13121110, and each vel_valid bit pulsed exactly once.
REQ-041 SHALL cover: ch_en=4'b0101 -> starts only for ch0 then ch2, with no idle cycle between STORE and the ch2 start, and vel_out slices 1 and 3 unchanged.
REQ-042 SHALL cover: done delayed 20 cycles with PRESCALE=16 -> overrun=1 and the scan completes all channels; err_clr then gives overrun=0.
REQ-043 SHALL cover: cfg_we to ch1 with kp=5 in the cycle ch1 operands latch -> old kp on pid_kp for ch1, and kp=5 at the next tick.
REQ-044 SHALL cover: rst asserted in WAIT for ch2 -> all outputs 0 next cycle, a late pid_done ignored, and a normal scan on the next tick.
REQ-045 SHALL cover: PID_SCHED_WATCHDOG_EN defined, TIMEOUT=8, no done for ch1 -> timeout_err=4'b0010 after 8 WAIT cycles, then ch2 issued.
